// File: rtl/id_token_fsm_pkg.sv
// Shared types and constants for the streaming identifier recognizer.
// Class codes, FSM state encoding and the ASCII bounds used by the decoder.
package id_token_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALPHA = 2'd1,
    S_DIGIT = 2'd2,
    S_LONG  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_LETTER = 2'd1,
    CLS_DIGIT  = 2'd2
  } cls_t;

  localparam logic [7:0] ASCII_UP_A = 8'h41;
  localparam logic [7:0] ASCII_UP_Z = 8'h5A;
  localparam logic [7:0] ASCII_LO_A = 8'h61;
  localparam logic [7:0] ASCII_LO_Z = 8'h7A;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_US   = 8'h5F;

endpackage

// File: rtl/id_char_class.sv
// Combinational character classifier: letter / digit / other.
// Define ID_UNDERSCORE_EN to class '_' as a letter (C-style identifiers).
module id_char_class
  import id_token_fsm_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] char,
  output cls_t              cls
);

  logic       upper_zero;
  logic [7:0] low;

  assign low = char[7:0];

  // Any set bit above the 8-bit code point makes the character "other".
  generate
    if (CHAR_W > 8) begin : g_wide
      assign upper_zero = ~|char[CHAR_W-1:8];
    end else begin : g_narrow
      assign upper_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    cls = CLS_OTHER;
    if (upper_zero) begin
      if ((low >= ASCII_UP_A && low <= ASCII_UP_Z) ||
          (low >= ASCII_LO_A && low <= ASCII_LO_Z)) begin
        cls = CLS_LETTER;
      end else if (low >= ASCII_0 && low <= ASCII_9) begin
        cls = CLS_DIGIT;
      end
`ifdef ID_UNDERSCORE_EN
      else if (low == ASCII_US) begin
        cls = CLS_LETTER;
      end
`endif
    end
  end

endmodule

// File: rtl/id_token_fsm.sv
// Streaming identifier recognizer: flags input ending in letter+ digit{MIN_DIGITS,}.
// Optional ID_UNDERSCORE_EN makes '_' a letter (handled in id_char_class).
module id_token_fsm
  import id_token_fsm_pkg::*;
#(
  parameter  int CHAR_W     = 8,
  parameter  int MAX_LEN    = 16,
  parameter  int MIN_DIGITS = 1,
  parameter  int CNT_W      = 8,
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] char,
  output logic              out,
  output logic              match,
  output logic [LEN_W-1:0]  len,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int DIG_W = $clog2(MIN_DIGITS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(MIN_DIGITS);
  localparam logic [DIG_W-1:0] DIG_ONE = DIG_W'(1);

  cls_t             cls;
  state_t           state, state_n;
  logic [LEN_W-1:0] len_n;
  logic [DIG_W-1:0] dig_cnt, dig_n;
  logic             out_n, match_n;
  logic [CNT_W-1:0] cnt_n;

  id_char_class #(.CHAR_W(CHAR_W)) u_class (
    .char (char),
    .cls  (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      dig_cnt   <= '0;
      out       <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      dig_cnt   <= dig_n;
      out       <= out_n;
      match     <= match_n;
      match_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    dig_n   = dig_cnt;
    if (in_valid) begin
      unique case (cls)
        CLS_LETTER: begin
          unique case (state)
            S_IDLE, S_ALPHA: begin
              if (len == LEN_MAX) begin
                state_n = S_LONG;
                dig_n   = '0;
              end else begin
                state_n = S_ALPHA;
                len_n   = len + LEN_ONE;
              end
            end
            // A letter after digits opens a fresh token.
            S_DIGIT: begin
              state_n = S_ALPHA;
              len_n   = LEN_ONE;
              dig_n   = '0;
            end
            default: ;
          endcase
        end
        CLS_DIGIT: begin
          unique case (state)
            S_IDLE: len_n = '0;
            S_ALPHA, S_DIGIT: begin
              if (len == LEN_MAX) begin
                state_n = S_LONG;
                dig_n   = '0;
              end else begin
                state_n = S_DIGIT;
                len_n   = len + LEN_ONE;
                if (state == S_ALPHA) begin
                  dig_n = DIG_ONE;
                end else if (dig_cnt != DIG_MAX) begin
                  dig_n = dig_cnt + DIG_ONE;
                end
              end
            end
            default: ;
          endcase
        end
        default: begin
          state_n = S_IDLE;
          len_n   = '0;
          dig_n   = '0;
        end
      endcase
    end

    out_n   = (state_n == S_DIGIT) && (dig_n >= DIG_MAX);
    match_n = in_valid && out_n && !out;
    cnt_n   = match_cnt;
    if (match_n && (match_cnt != {CNT_W{1'b1}})) begin
      cnt_n = match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_token_fsm.sv
// Bench for id_token_fsm: three configurations driven in lockstep from one stream,
// checked against a run-scanning reference model plus fixed vectors and corner sequences.
module tb_id_token_fsm;

`ifdef ID_UNDERSCORE_EN
  localparam bit US_EN = 1'b1;
`else
  localparam bit US_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] char = 8'h20;

  logic       out_a, match_a, out_s, match_s, out_m, match_m;
  logic [4:0] len_a, len_m;
  logic [2:0] len_s;
  logic [7:0] cnt_a, cnt_m;
  logic [1:0] cnt_s;

  // Defaults; short tokens with a 2-bit counter; two required digits.
  id_token_fsm dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(char),
    .out(out_a), .match(match_a), .len(len_a), .match_cnt(cnt_a));
  id_token_fsm #(.MAX_LEN(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(char),
    .out(out_s), .match(match_s), .len(len_s), .match_cnt(cnt_s));
  id_token_fsm #(.MIN_DIGITS(2)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(char),
    .out(out_m), .match(match_m), .len(len_m), .match_cnt(cnt_m));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: characters of the current run since the last OTHER.
  logic [7:0] run_q[$];
  int cfg_max_len[3] = '{16, 4, 16};
  int cfg_min_dig[3] = '{1, 1, 2};
  int cfg_cnt_max[3] = '{255, 3, 255};
  bit m_out[3];
  bit m_match[3];
  int m_len[3];
  int m_cnt[3];

  function automatic int cls_of(input logic [7:0] c);
    if ((c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A)) return 1;
    if (c >= 8'h30 && c <= 8'h39) return 2;
    if (US_EN && c == 8'h5F) return 1;
    return 0;
  endfunction

  // Splits the run into letter+digit* segments (leading digits ignored);
  // any segment longer than max_len poisons the rest of the run.
  function automatic void model_eval(input int max_len, input int min_dig,
                                     output bit o, output int l);
    int  seg_len = 0;
    int  seg_dig = 0;
    bit  started = 0;
    bit  too_long = 0;
    foreach (run_q[i]) begin
      int c = cls_of(run_q[i]);
      if (!started) begin
        if (c == 1) begin
          started = 1;
          seg_len = 1;
          seg_dig = 0;
        end
      end else if (c == 1 && seg_dig > 0) begin
        seg_len = 1;
        seg_dig = 0;
      end else begin
        seg_len++;
        if (c == 2) seg_dig++;
      end
      if (seg_len > max_len) too_long = 1;
    end
    if (too_long) begin
      o = 0; l = max_len;
    end else if (!started) begin
      o = 0; l = 0;
    end else begin
      o = (seg_dig >= min_dig); l = seg_len;
    end
  endfunction

  task automatic model_reset();
    run_q.delete();
    for (int k = 0; k < 3; k++) begin
      m_out[k] = 0; m_match[k] = 0; m_len[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] c);
    bit o;
    int l;
    if (v) begin
      if (cls_of(c) == 0) run_q.delete();
      else run_q.push_back(c);
    end
    for (int k = 0; k < 3; k++) begin
      if (v) begin
        model_eval(cfg_max_len[k], cfg_min_dig[k], o, l);
        m_match[k] = o && !m_out[k];
        m_out[k] = o;
        m_len[k] = l;
        if (m_match[k] && m_cnt[k] < cfg_cnt_max[k]) m_cnt[k]++;
      end else begin
        m_match[k] = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("a_out", out_a, m_out[0]);     check("a_match", match_a, m_match[0]);
    check("a_len", len_a, m_len[0]);     check("a_cnt", cnt_a, m_cnt[0]);
    check("s_out", out_s, m_out[1]);     check("s_match", match_s, m_match[1]);
    check("s_len", len_s, m_len[1]);     check("s_cnt", cnt_s, m_cnt[1]);
    check("m_out", out_m, m_out[2]);     check("m_match", match_m, m_match[2]);
    check("m_len", len_m, m_len[2]);     check("m_cnt", cnt_m, m_cnt[2]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_a"}, out_a, 0);  check({tag, "_match_a"}, match_a, 0);
    check({tag, "_len_a"}, len_a, 0);  check({tag, "_cnt_a"}, cnt_a, 0);
    check({tag, "_out_s"}, out_s, 0);  check({tag, "_len_s"}, len_s, 0);
    check({tag, "_cnt_s"}, cnt_s, 0);  check({tag, "_out_m"}, out_m, 0);
    check({tag, "_len_m"}, len_m, 0);  check({tag, "_cnt_m"}, cnt_m, 0);
  endtask

  // Drive on the falling edge, let the DUT consume on the rising edge, sample 1ns later.
  task automatic step(input bit v, input logic [7:0] c);
    @(negedge clk);
    in_valid = v;
    char = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    check_model();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         v;
    logic [7:0] c;
    bit         e_out;
    bit         e_match;
    int         e_len;
    int         e_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, "a", 0, 0, 1, 0};
    vecs[1]  = '{1, "b", 0, 0, 2, 0};
    vecs[2]  = '{1, "1", 1, 1, 3, 1};
    vecs[3]  = '{1, "2", 1, 0, 4, 1};
    vecs[4]  = '{1, "q", 0, 0, 1, 1};
    vecs[5]  = '{1, " ", 0, 0, 0, 1};
    vecs[6]  = '{1, "1", 0, 0, 0, 1};
    vecs[7]  = '{1, "a", 0, 0, 1, 1};
    vecs[8]  = '{1, "1", 1, 1, 2, 2};
    vecs[9]  = '{1, " ", 0, 0, 0, 2};
    vecs[10] = '{1, "9", 0, 0, 0, 2};
    vecs[11] = '{0, "7", 0, 0, 0, 2};
    vecs[12] = '{1, "z", 0, 0, 1, 2};
    vecs[13] = '{0, "z", 0, 0, 1, 2};
    vecs[14] = '{1, "0", 1, 1, 2, 3};

    model_reset();
    #2;
    check_zero("por");
    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].c);
      check($sformatf("vec%0d_out", i), out_a, vecs[i].e_out);
      check($sformatf("vec%0d_match", i), match_a, vecs[i].e_match);
      check($sformatf("vec%0d_len", i), len_a, vecs[i].e_len);
      check($sformatf("vec%0d_cnt", i), cnt_a, vecs[i].e_cnt);
    end

    // Two required digits: output rises on the second digit only.
    send_str(" x5");
    check("min2_one_digit", out_m, 0);
    step(1'b1, "6");
    check("min2_out", out_m, 1);
    check("min2_match", match_m, 1);
    step(1'b1, "7");
    check("min2_hold", out_m, 1);
    check("min2_no_repulse", match_m, 0);

    // Length boundary on the MAX_LEN=4 instance.
    send_str(" abc1");
    check("len4_out", out_s, 1);
    check("len4_len", len_s, 4);
    step(1'b1, "2");
    check("len5_out", out_s, 0);
    check("len5_len", len_s, 4);
    send_str("a3");
    check("long_letter_out", out_s, 0);
    check("long_letter_len", len_s, 4);
    send_str(" a1");
    check("after_long_out", out_s, 1);
    check("after_long_len", len_s, 2);

    // Idle cycles between letter and digit freeze everything.
    send_str(" a");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom_range(0, 255)));
      check("hold_out", out_a, 0);
      check("hold_len", len_a, 1);
      check("hold_match", match_a, 0);
    end
    step(1'b1, "1");
    check("hold_then_out", out_a, 1);
    check("hold_then_match", match_a, 1);

    // Counter saturation on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_str("a1 ");
      check("cnt_sat", cnt_s, (i + 1 > 3) ? 3 : i + 1);
    end

    send_str(" _1");
    check("underscore_out", out_a, US_EN ? 1 : 0);
    send_str(" a_1");
    check("a_us_1_out", out_a, US_EN ? 1 : 0);

    // Asynchronous reset mid-token, applied between clock edges.
    send_str(" a1");
    check("pre_async_out", out_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, "1");
    check("post_rst_digit_len", len_a, 0);

    for (int n = 0; n < 800; n++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    c = 8'($urandom_range(97, 122));
        2:       c = 8'($urandom_range(65, 90));
        3, 4, 5: c = 8'($urandom_range(48, 57));
        6:       c = " ";
        7:       c = 8'h5F;
        default: c = 8'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 7) != 0, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
